// File: rtl/ioctl_sdram_writer_if.sv
// ioctl download bus plus SDRAM client write port.
// slave is the writer; master is the initiator/controller side.
interface ioctl_sdram_writer_if #(
  parameter int ADDR_W = 25
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wait;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;

  modport slave (
    input  ioctl_download, ioctl_index,
    input  ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output mem_req, mem_addr, mem_wdata,
    input  mem_ack
  );

  modport master (
    output ioctl_download, ioctl_index,
    output ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  mem_req, mem_addr, mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/ioctl_sdram_writer.sv
// ioctl download responder: FIFO-buffers strobed
// words and writes them to an SDRAM client port.
module ioctl_sdram_writer #(
  parameter int              ADDR_W = 25,
  parameter logic [7:0]      INDEX  = 8'h00,
  parameter logic [ADDR_W-1:0] BASE = '0,
  parameter bit              SWAP   = 1'b0,
  parameter int              DEPTH  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  ioctl_sdram_writer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              overrun,
  output logic              misalign
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, DRAIN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wait_q, wait_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              ovr_q, ovr_d;
  logic              mis_q, mis_d;

  entry_t            in_e;
  logic [ADDR_W-1:0] sum;
  logic              selected;
  logic              fall;
  logic              push_req;
  logic              push;
  logic              pop;

  assign selected = bus.ioctl_download &&
                    bus.ioctl_index == INDEX;
  assign fall     = state_q == ACTIVE &&
                    !bus.ioctl_download;
  assign push_req = bus.ioctl_wr &&
                    ((selected && state_q != DRAIN) || fall);
  assign pop      = req_q && bus.mem_ack;
  assign push     = push_req && (count_q != FULL || pop);
  assign sum      = BASE + fifo_q[rd_ptr_q].addr;

  always_comb begin
    in_e.addr = {bus.ioctl_addr[ADDR_W-1:1], 1'b0};
    in_e.data = SWAP ?
      {bus.ioctl_dout[7:0], bus.ioctl_dout[15:8]} :
      bus.ioctl_dout;
  end

  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wcnt_d   = wcnt_q;
    ovr_d    = ovr_q;
    mis_d    = mis_q;

    unique case (state_q)
      IDLE: if (selected) begin
        state_d = ACTIVE;
        wcnt_d  = '0;
        ovr_d   = 1'b0;
        mis_d   = 1'b0;
        busy_d  = 1'b1;
      end
      ACTIVE: if (!bus.ioctl_download) begin
        state_d = DRAIN;
      end
      DRAIN: if (count_q == '0 && !req_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Sticky flags set after the FSM so a strobe in
    // the start cycle is not lost to the clear.
    if (push_req && bus.ioctl_addr[0]) mis_d = 1'b1;
    if (push_req && !push) ovr_d = 1'b1;

    if (push) begin
      fifo_d[wr_ptr_q] = in_e;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      req_d    = 1'b0;
      wcnt_d   = wcnt_q + 1'b1;
    end else if (!req_q && count_q != '0) begin
      req_d   = 1'b1;
      addr_d  = {sum[ADDR_W-1:1], 1'b0};
      wdata_d = fifo_q[rd_ptr_q].data;
    end

    count_d = count_q + CW'(push) - CW'(pop);
    wait_d  = count_d >= HIGH || state_d == DRAIN;
  end

  always_ff @(posedge clk_sys) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wcnt_q   <= '0;
      ovr_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wcnt_q   <= wcnt_d;
      ovr_q    <= ovr_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign word_count     = wcnt_q;
  assign overrun        = ovr_q;
  assign misalign       = mis_q;
endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// Bench for ioctl_sdram_writer: two instances
// (plain, and swapped with a base offset) on one bus.
module tb_ioctl_sdram_writer;
  typedef struct {
    logic [1:0][24:0] a;
    logic [1:0][15:0] d;
  } exp_t;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] dout;
    logic [24:0] ea0;
    logic [15:0] ed0;
    logic [24:0] ea1;
    logic [15:0] ed1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic dl;
  logic [7:0] idx;
  logic wr;
  logic [24:0] addr;
  logic [15:0] dout;
  logic [1:0] ack;
  logic [1:0] wait_w, req_w;
  logic [1:0][24:0] maddr;
  logic [1:0][15:0] mdata;
  logic [1:0] busy, done, ovr, mis;
  logic [1:0][24:0] wcnt;

  int tests = 0;
  int errors = 0;
  int ack_delay;
  int done_cnt [2];
  int req_rise [2];
  int rd_idx [2];
  int dly_cnt [2];
  logic [1:0] req_seen;
  exp_t exp_list [$];
  vec_t vt [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    ioctl_sdram_writer_if #(.ADDR_W(25)) bus ();
    assign bus.ioctl_download = dl;
    assign bus.ioctl_index    = idx;
    assign bus.ioctl_wr       = wr;
    assign bus.ioctl_addr     = addr;
    assign bus.ioctl_dout     = dout;
    assign bus.mem_ack        = ack[g];
    assign wait_w[g] = bus.ioctl_wait;
    assign req_w[g]  = bus.mem_req;
    assign maddr[g]  = bus.mem_addr;
    assign mdata[g]  = bus.mem_wdata;

    ioctl_sdram_writer #(
      .ADDR_W(25),
      .INDEX (8'h00),
      .BASE  (g == 0 ? 25'h0 : 25'h100),
      .SWAP  (g == 1),
      .DEPTH (4)
    ) u_dut (
      .clk_sys   (clk),
      .reset_n   (rst_n),
      .bus       (bus),
      .busy      (busy[g]),
      .done      (done[g]),
      .word_count(wcnt[g]),
      .overrun   (ovr[g]),
      .misalign  (mis[g])
    );
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(
    input logic [24:0] a, input logic [15:0] d);
    exp_t e;
    logic [24:0] ae;
    ae = {a[24:1], 1'b0};
    e.a[0] = ae;
    e.a[1] = ae + 25'h100;
    e.d[0] = d;
    e.d[1] = {d[7:0], d[15:8]};
    return e;
  endfunction

  task automatic check_write(input int g);
    if (rd_idx[g] >= exp_list.size()) begin
      tests++;
      errors++;
      $display("FAIL unexpected_write dut%0d: addr %0h data %0h",
               g, maddr[g], mdata[g]);
    end else begin
      chk($sformatf("wr_addr dut%0d #%0d", g, rd_idx[g]),
          64'(maddr[g]), 64'(exp_list[rd_idx[g]].a[g]));
      chk($sformatf("wr_data dut%0d #%0d", g, rd_idx[g]),
          64'(mdata[g]), 64'(exp_list[rd_idx[g]].d[g]));
      rd_idx[g]++;
    end
  endtask

  // One cycle: sample at negedge, run ack responders.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      if (done[g]) done_cnt[g]++;
      if (req_w[g] && !req_seen[g]) req_rise[g]++;
      req_seen[g] = req_w[g];
      if (ack[g]) begin
        ack[g] = 1'b0;
      end else if (req_w[g]) begin
        if (dly_cnt[g] >= ack_delay) begin
          ack[g] = 1'b1;
          dly_cnt[g] = 0;
          check_write(g);
        end else begin
          dly_cnt[g]++;
        end
      end else begin
        dly_cnt[g] = 0;
      end
    end
  endtask

  task automatic strobe(input logic [24:0] a,
                        input logic [15:0] d,
                        input bit honor,
                        input bit expect_wr);
    int t;
    t = 0;
    if (honor) begin
      while (wait_w[0] && t < 300) begin
        tick();
        t++;
      end
      if (wait_w[0]) chk("wait_timeout", 1, 0);
    end
    wr = 1'b1;
    addr = a;
    dout = d;
    if (expect_wr) exp_list.push_back(mk_exp(a, d));
    tick();
    wr = 1'b0;
  endtask

  task automatic finish_dl(input bit fs,
                           input logic [24:0] a,
                           input logic [15:0] d);
    int b0, b1, t;
    b0 = done_cnt[0];
    b1 = done_cnt[1];
    dl = 1'b0;
    if (fs) begin
      wr = 1'b1;
      addr = a;
      dout = d;
      exp_list.push_back(mk_exp(a, d));
    end
    tick();
    wr = 1'b0;
    chk("drain_wait", 64'(wait_w[0]), 1);
    t = 0;
    while (done_cnt[0] == b0 && t < 500) begin
      tick();
      t++;
    end
    chk("done_seen", 64'(done_cnt[0] - b0), 1);
    chk("done_busy", 64'(busy[0]), 0);
    chk("done_empty0",
        64'(rd_idx[0] == exp_list.size()), 1);
    repeat (3) tick();
    chk("done_once", 64'(done_cnt[0] - b0), 1);
    chk("done_dut1", 64'(done_cnt[1] - b1), 1);
    chk("done_empty1",
        64'(rd_idx[1] == exp_list.size()), 1);
  endtask

  initial begin
    int rr, bd, t;
    vt[0] = '{25'h10, 16'hBEEF,
              25'h10, 16'hBEEF, 25'h110, 16'hEFBE};
    vt[1] = '{25'h2, 16'h1234,
              25'h2, 16'h1234, 25'h102, 16'h3412};
    vt[2] = '{25'h5, 16'h55AA,
              25'h4, 16'h55AA, 25'h104, 16'hAA55};
    vt[3] = '{25'h1FFFFFE, 16'h00FF,
              25'h1FFFFFE, 16'h00FF, 25'hFE, 16'hFF00};
    vt[4] = '{25'h0, 16'h8001,
              25'h0, 16'h8001, 25'h100, 16'h0180};

    rst_n = 1'b0;
    dl = 1'b0;
    idx = 8'h00;
    wr = 1'b0;
    addr = '0;
    dout = '0;
    ack = '0;
    req_seen = '0;
    ack_delay = 1;
    for (int g = 0; g < 2; g++) begin
      done_cnt[g] = 0;
      req_rise[g] = 0;
      rd_idx[g] = 0;
      dly_cnt[g] = 0;
    end
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_outs dut%0d", g),
          64'({wait_w[g], req_w[g], maddr[g],
               mdata[g], busy[g], done[g]}), 0);
      chk($sformatf("reset_stat dut%0d", g),
          64'({wcnt[g], ovr[g], mis[g]}), 0);
    end
    rst_n = 1'b1;
    tick();

    // Table: basic, swap/base, misalign, wrap.
    dl = 1'b1;
    tick();
    chk("start_busy", 64'(busy[0]), 1);
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.a[0] = vt[i].ea0;
      e.d[0] = vt[i].ed0;
      e.a[1] = vt[i].ea1;
      e.d[1] = vt[i].ed1;
      while (wait_w[0]) tick();
      exp_list.push_back(e);
      strobe(vt[i].addr, vt[i].dout, 1'b1, 1'b0);
    end
    finish_dl(1'b0, '0, '0);
    chk("tbl_wcnt0", 64'(wcnt[0]), 5);
    chk("tbl_wcnt1", 64'(wcnt[1]), 5);
    chk("tbl_misalign", 64'(mis[0]), 1);
    chk("tbl_overrun", 64'(ovr[0]), 0);

    // Backpressure with a slow port.
    ack_delay = 20;
    dl = 1'b1;
    tick();
    chk("bp_cleared", 64'({mis[0], wcnt[0]}), 0);
    for (int i = 0; i < 16; i++) begin
      strobe(25'(i * 2), 16'(16'hA000 + i),
             1'b1, 1'b1);
      if (i == 1) chk("bp_wait_at2", 64'(wait_w[0]), 0);
      if (i == 2) chk("bp_wait_at3", 64'(wait_w[0]), 1);
    end
    finish_dl(1'b0, '0, '0);
    chk("bp_wcnt", 64'(wcnt[0]), 16);
    chk("bp_overrun", 64'(ovr[0]), 0);

    // Ignore wait on a stalled port: two words drop.
    ack_delay = 30;
    rr = req_rise[0];
    dl = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      strobe(25'(25'h40 + 2 * i), 16'(16'hC000 + i),
             1'b0, i < 4);
    end
    chk("ovr_flag", 64'(ovr[0]), 1);
    finish_dl(1'b0, '0, '0);
    chk("ovr_writes", 64'(req_rise[0] - rr), 4);
    chk("ovr_wcnt", 64'(wcnt[0]), 4);

    // Index filter.
    ack_delay = 1;
    rr = req_rise[0];
    idx = 8'h01;
    dl = 1'b1;
    tick();
    strobe(25'h80, 16'h1111, 1'b0, 1'b0);
    repeat (6) tick();
    chk("idx_noreq", 64'(req_rise[0] - rr), 0);
    chk("idx_nobusy", 64'(busy[0]), 0);
    dl = 1'b0;
    idx = 8'h00;
    tick();

    // Strobe coincident with the download falling.
    dl = 1'b1;
    tick();
    strobe(25'h90, 16'h2222, 1'b1, 1'b1);
    finish_dl(1'b1, 25'h92, 16'h3333);
    chk("fall_wcnt", 64'(wcnt[0]), 2);

    // Reset while a write is outstanding.
    ack_delay = 40;
    dl = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      strobe(25'(25'hA0 + 2 * i), 16'(16'h7000 + i),
             1'b1, 1'b1);
    end
    t = 0;
    while (!req_w[0] && t < 10) begin
      tick();
      t++;
    end
    chk("rst_pre_req", 64'(req_w[0]), 1);
    bd = done_cnt[0];
    rst_n = 1'b0;
    dl = 1'b0;
    tick();
    chk("rst_req_low", 64'(req_w[0]), 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_outs dut%0d", g),
          64'({wait_w[g], req_w[g], maddr[g],
               mdata[g], busy[g], done[g]}), 0);
      chk($sformatf("rst_stat dut%0d", g),
          64'({wcnt[g], ovr[g], mis[g]}), 0);
      rd_idx[g] = exp_list.size();
    end
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rst_no_done", 64'(done_cnt[0] - bd), 0);
    chk("rst_idle_req", 64'(req_w[0]), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, errors);
    $finish;
  end
endmodule
